// File: rtl/bf_pkg.sv
// Shared constants, FSM state type and the per-brick term helper for the
// brick product accumulator.
package bf_pkg;

  localparam int BRICK_PROD_W = 6;
  localparam int NUM_BRICKS   = 16;
  localparam int SHIFT_W      = 4;
  localparam int ACC_W        = 32;
  localparam int CNT_W        = 16;
  // Exact width of one shifted brick product for any SHIFT_W-bit shift amount.
  localparam int TERM_W       = BRICK_PROD_W + (1 << SHIFT_W) - 1;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } accum_state_t;

  function automatic logic signed [TERM_W-1:0] brick_term(
    input logic [BRICK_PROD_W-1:0] prod,
    input logic [SHIFT_W-1:0]      shift,
    input logic                    en
  );
    logic signed [TERM_W-1:0] ext;
    ext = TERM_W'($signed(prod));
    brick_term = en ? (ext <<< shift) : '0;
  endfunction

endpackage

// File: rtl/brick_adder_tree.sv
// Combinational signed sum of N packed terms, widened to OUT_W so the caller
// can detect whether the true sum fits its own accumulator width.
module brick_adder_tree #(
  parameter int N     = bf_pkg::NUM_BRICKS,
  parameter int IN_W  = bf_pkg::ACC_W,
  parameter int OUT_W = bf_pkg::ACC_W + 5
) (
  input  logic [N*IN_W-1:0]       terms_i,
  output logic signed [OUT_W-1:0] sum_o
);

  // Widened accumulation of all terms.
  always_comb begin
    sum_o = '0;
    for (int i = 0; i < N; i++) begin
      sum_o = sum_o + OUT_W'($signed(terms_i[i*IN_W +: IN_W]));
    end
  end

endmodule

// File: rtl/brick_shift_accum.sv
// Sign-extends, shifts and sums the brick products of each beat, accumulates a
// dot-product window and returns the result over a valid/ready handshake.
module brick_shift_accum #(
  parameter int NUM_BRICKS = bf_pkg::NUM_BRICKS,
  parameter int SHIFT_W    = bf_pkg::SHIFT_W,
  parameter int ACC_W      = bf_pkg::ACC_W,
  parameter int CNT_W      = bf_pkg::CNT_W
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [NUM_BRICKS*6-1:0] prod_in,
  input  logic [NUM_BRICKS*SHIFT_W-1:0] shift_in,
  input  logic [NUM_BRICKS-1:0]   brick_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_data,
  output logic [CNT_W-1:0]        out_beats,
  output logic                    out_ovf
);
  import bf_pkg::*;

  localparam int SUM_W  = ACC_W + $clog2(NUM_BRICKS) + 1;
  localparam int WIDE_W = (TERM_W > ACC_W) ? TERM_W : ACC_W;

  logic signed [TERM_W-1:0]    term_full_s [NUM_BRICKS];
  logic signed [WIDE_W-1:0]    term_wide_s [NUM_BRICKS];
  logic [NUM_BRICKS*ACC_W-1:0] terms_s;
  logic                        term_wrap_s;
  logic signed [SUM_W-1:0]     sum_wide_s;
  logic signed [ACC_W-1:0]     sum_acc_s;
  logic                        sum_wrap_s;
  logic                        accept_s;
  logic signed [ACC_W-1:0]     acc_sum_s;
  logic                        add_ovf_s;

  accum_state_t            state_q, state_d;
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_last_q, s1_last_d;
  logic signed [ACC_W-1:0] s1_sum_q, s1_sum_d;
  logic                    s1_ovf_q, s1_ovf_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    last_done_q, last_done_d;
  logic                    out_valid_q, out_valid_d;
  logic [ACC_W-1:0]        out_data_q, out_data_d;
  logic [CNT_W-1:0]        out_beats_q, out_beats_d;
  logic                    out_ovf_q, out_ovf_d;

  // Per-brick terms truncated to ACC_W, flagging any term that does not fit.
  always_comb begin
    terms_s     = '0;
    term_wrap_s = 1'b0;
    for (int i = 0; i < NUM_BRICKS; i++) begin
      term_full_s[i] = brick_term(prod_in[i*BRICK_PROD_W +: BRICK_PROD_W],
                                  shift_in[i*SHIFT_W +: SHIFT_W], brick_en[i]);
      term_wide_s[i] = WIDE_W'(term_full_s[i]);
      terms_s[i*ACC_W +: ACC_W] = term_wide_s[i][ACC_W-1:0];
      term_wrap_s = term_wrap_s |
                    (WIDE_W'($signed(term_wide_s[i][ACC_W-1:0])) != term_wide_s[i]);
    end
  end

  brick_adder_tree #(
    .N     (NUM_BRICKS),
    .IN_W  (ACC_W),
    .OUT_W (SUM_W)
  ) u_tree (
    .terms_i (terms_s),
    .sum_o   (sum_wide_s)
  );

  assign sum_acc_s  = sum_wide_s[ACC_W-1:0];
  assign sum_wrap_s = SUM_W'(sum_acc_s) != sum_wide_s;
  assign in_ready   = (state_q == ACCUM);
  assign accept_s   = in_valid && in_ready;
  assign acc_sum_s  = acc_q + s1_sum_q;
  assign add_ovf_s  = (acc_q[ACC_W-1] == s1_sum_q[ACC_W-1]) &&
                      (acc_sum_s[ACC_W-1] != acc_q[ACC_W-1]);

  // Next-state for the beat stage, accumulator, counter and window FSM.
  always_comb begin
    state_d     = state_q;
    s1_valid_d  = 1'b0;
    s1_last_d   = s1_last_q;
    s1_sum_d    = s1_sum_q;
    s1_ovf_d    = s1_ovf_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    last_done_d = last_done_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
    out_ovf_d   = out_ovf_q;
    if (clear) begin
      state_d     = ACCUM;
      acc_d       = '0;
      ovf_d       = 1'b0;
      cnt_d       = '0;
      last_done_d = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (accept_s) begin
        s1_valid_d = 1'b1;
        s1_last_d  = in_last;
        s1_sum_d   = sum_acc_s;
        s1_ovf_d   = term_wrap_s | sum_wrap_s;
        cnt_d      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1'b1);
      end else begin
        s1_valid_d = 1'b0;
      end
      if (s1_valid_q) begin
        acc_d       = acc_sum_s;
        ovf_d       = ovf_q | add_ovf_s | s1_ovf_q;
        last_done_d = s1_last_q;
      end else begin
        acc_d = acc_q;
      end
      case (state_q)
        ACCUM: state_d = (accept_s && in_last) ? FLUSH : ACCUM;
        // The last beat reaches acc one edge after acceptance; load on the next.
        FLUSH: begin
          if (last_done_q) begin
            out_data_d  = acc_q;
            out_beats_d = cnt_q;
            out_ovf_d   = ovf_q;
            out_valid_d = 1'b1;
            last_done_d = 1'b0;
            state_d     = HOLD;
          end else begin
            state_d = FLUSH;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            last_done_d = 1'b0;
            state_d     = ACCUM;
          end else begin
            state_d = HOLD;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ACCUM;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sum_q    <= '0;
      s1_ovf_q    <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      last_done_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_sum_q    <= s1_sum_d;
      s1_ovf_q    <= s1_ovf_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      last_done_q <= last_done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_beats = out_beats_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_brick_shift_accum.sv
// Randomized and directed windows against an arithmetic reference model of the
// brick accumulator.
module tb_brick_shift_accum;

  localparam int NB = 16;
  localparam int SW = 4;
  localparam int AW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic [NB*6-1:0]  prod_in = '0;
  logic [NB*SW-1:0] shift_in = '0;
  logic [NB-1:0]    brick_en = '0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ovf;
  logic [AW-1:0]    out_data;
  logic [CW-1:0]    out_beats;

  int n_vec = 0;
  int n_miscmp = 0;

  logic [NB*6-1:0]  w_p [256];
  logic [NB*SW-1:0] w_s [256];
  logic [NB-1:0]    w_e [256];
  bit               w_gap [256];

  brick_shift_accum dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .prod_in   (prod_in),
    .shift_in  (shift_in),
    .brick_en  (brick_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_beats (out_beats),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: each enabled brick is its signed product times 2**shift.
  function automatic longint beat_sum(input logic [NB*6-1:0] p, input logic [NB*SW-1:0] s,
                                      input logic [NB-1:0] e);
    longint tot = 0;
    for (int i = 0; i < NB; i++) begin
      logic [5:0]    pv;
      logic [SW-1:0] sv;
      pv = p[i*6 +: 6];
      sv = s[i*SW +: SW];
      if (e[i]) tot += longint'($signed(pv)) * (longint'(1) << sv);
    end
    return tot;
  endfunction

  task automatic rand_beat(input int b);
    w_p[b] = {$urandom, $urandom, $urandom};
    for (int i = 0; i < NB; i++) begin
      w_s[b][i*SW +: SW] = ($urandom_range(0, 7) == 0) ? SW'($urandom_range(0, 15))
                                                       : SW'(2 * $urandom_range(0, 6));
    end
    w_e[b]   = ($urandom_range(0, 9) == 0) ? '0 : NB'($urandom);
    w_gap[b] = ($urandom_range(0, 3) == 0);
  endtask

  task automatic clear_beat(input int b);
    w_p[b]   = '0;
    w_s[b]   = '0;
    w_e[b]   = '0;
    w_gap[b] = 1'b0;
  endtask

  // end_mode: 0 = handshake after bp stall cycles, 1 = clear in HOLD, 2 = reset in HOLD.
  task automatic run_window(input string name, input int nb, input int clr_at,
                            input int bp, input int end_mode);
    longint acc = 0;
    longint nx;
    bit     ovf = 1'b0;
    int     cnt = 0;
    logic [AW-1:0] exp_d;
    for (int b = 0; b < nb; b++) begin
      if (w_gap[b]) begin
        in_valid = 1'b0;
        clear    = 1'b0;
        step();
      end
      prod_in  = w_p[b];
      shift_in = w_s[b];
      brick_en = w_e[b];
      in_valid = 1'b1;
      in_last  = (b == nb - 1);
      clear    = (b == clr_at);
      chk({name, "_in_ready_beat"}, 64'(in_ready), 64'(1));
      if (b == clr_at) begin
        acc = 0;
        ovf = 1'b0;
        cnt = 0;
      end else begin
        nx = acc + beat_sum(w_p[b], w_s[b], w_e[b]);
        if (nx != longint'(int'(nx))) ovf = 1'b1;
        acc = longint'(int'(nx));
        if (cnt < 65535) cnt++;
      end
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    clear    = 1'b0;
    chk({name, "_in_ready_flush"}, 64'(in_ready), 64'(0));
    chk({name, "_out_valid_t0"}, 64'(out_valid), 64'(0));
    step();
    chk({name, "_out_valid_t1"}, 64'(out_valid), 64'(0));
    step();
    chk({name, "_out_valid_t2"}, 64'(out_valid), 64'(1));
    exp_d = acc[AW-1:0];
    chk({name, "_out_data"}, 64'(out_data), 64'(exp_d));
    chk({name, "_out_beats"}, 64'(out_beats), 64'(cnt));
    chk({name, "_out_ovf"}, 64'(out_ovf), 64'(ovf));
    case (end_mode)
      1: begin
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk({name, "_hold_clear_valid"}, 64'(out_valid), 64'(0));
        chk({name, "_hold_clear_ready"}, 64'(in_ready), 64'(1));
      end
      2: begin
        #2;
        n_rst = 1'b0;
        #1;
        chk({name, "_rst_valid"}, 64'(out_valid), 64'(0));
        chk({name, "_rst_data"}, 64'(out_data), 64'(0));
        chk({name, "_rst_beats"}, 64'(out_beats), 64'(0));
        chk({name, "_rst_ovf"}, 64'(out_ovf), 64'(0));
        #2;
        n_rst = 1'b1;
        step();
        chk({name, "_rst_ready"}, 64'(in_ready), 64'(1));
        chk({name, "_rst_valid_after"}, 64'(out_valid), 64'(0));
      end
      default: begin
        for (int k = 0; k < bp; k++) begin
          chk({name, "_bp_valid"}, 64'(out_valid), 64'(1));
          chk({name, "_bp_ready"}, 64'(in_ready), 64'(0));
          chk({name, "_bp_data"}, 64'(out_data), 64'(exp_d));
          step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, "_post_hs_valid"}, 64'(out_valid), 64'(0));
        chk({name, "_post_hs_ready"}, 64'(in_ready), 64'(1));
      end
    endcase
  endtask

  initial begin
    #22;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_out_data", 64'(out_data), 64'(0));
    chk("reset_out_beats", 64'(out_beats), 64'(0));
    chk("reset_out_ovf", 64'(out_ovf), 64'(0));
    n_rst = 1'b1;
    step();
    chk("reset_in_ready", 64'(in_ready), 64'(1));

    // -4 + 9*16 = 140
    clear_beat(0);
    w_p[0][5:0]  = 6'h3C;
    w_p[0][11:6] = 6'd9;
    w_s[0][7:4]  = 4'd4;
    w_e[0]       = 16'h0003;
    run_window("single", 1, -1, 0, 0);

    // 5, -7, 100 with an idle gap before the third beat, then 5 stall cycles.
    clear_beat(0);
    clear_beat(1);
    clear_beat(2);
    w_p[0][5:0] = 6'd5;
    w_e[0]      = 16'h0001;
    w_p[1][5:0] = 6'h39;
    w_e[1]      = 16'h0001;
    w_p[2][5:0] = 6'd25;
    w_s[2][3:0] = 4'd2;
    w_e[2]      = 16'h0001;
    w_gap[2]    = 1'b1;
    run_window("three_beat", 3, -1, 5, 0);

    // Masked bricks carry nonzero products; second beat fully disabled.
    for (int b = 0; b < 2; b++) begin
      clear_beat(b);
      for (int i = 0; i < NB; i++) begin
        w_p[b][i*6 +: 6]   = 6'd31;
        w_s[b][i*SW +: SW] = 4'd2;
      end
    end
    w_e[0] = 16'h0001;
    w_e[1] = 16'h0000;
    run_window("sparse", 2, -1, 0, 0);

    // 130 beats of -2**24 wrap a 32-bit accumulator.
    for (int b = 0; b < 130; b++) begin
      clear_beat(b);
      for (int i = 0; i < NB; i++) begin
        w_p[b][i*6 +: 6]   = 6'h20;
        w_s[b][i*SW +: SW] = 4'd15;
      end
      w_e[b] = 16'hFFFF;
    end
    run_window("overflow", 130, -1, 1, 0);

    for (int b = 0; b < 5; b++) rand_beat(b);
    run_window("clear_mid", 5, 2, 0, 0);

    for (int b = 0; b < 3; b++) rand_beat(b);
    run_window("clear_hold", 3, -1, 0, 1);

    // 9*4 + 1 = 37, reset while the result is held.
    clear_beat(0);
    w_p[0][5:0]  = 6'd9;
    w_s[0][3:0]  = 4'd2;
    w_p[0][11:6] = 6'd1;
    w_e[0]       = 16'h0003;
    run_window("reset_hold", 1, -1, 2, 2);

    for (int w = 0; w < 25; w++) begin
      int nb;
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) rand_beat(b);
      run_window("random", nb, ($urandom_range(0, 4) == 0) ? $urandom_range(0, nb - 2) : -1,
                 $urandom_range(0, 3), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/brick_shift_accum.md
Name: brick_shift_accum

Overview:
- Downstream consumer of the 2-bit bit_brick multipliers in the weight-sparse systolic PE.
- Each beat takes NUM_BRICKS signed 6-bit brick products, each with a shift amount and an enable bit.
- Sign-extends and shifts each product, sums them in a registered adder stage, and accumulates across a multi-beat dot-product window.
- Emits the final sum on a valid/ready output handshake.

Parameters:
- NUM_BRICKS, 16, brick products consumed per beat (4x4 fusion array).
- SHIFT_W, 4, width of each per-brick shift amount (legal values 0..12, even).
- ACC_W, 32, accumulator and output width.
- CNT_W, 16, width of the beat counter.

Ports:
- clk  input  1  clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort: drop the window, return to ACCUM with acc=0.
- in_valid  input  1  beat valid.
- in_ready  output  1  block can accept a beat.
- in_last  input  1  beat is the last of the window.
- prod_in  input  NUM_BRICKS*6  brick products, two's complement, brick i at [6i+5:6i].
- shift_in  input  NUM_BRICKS*SHIFT_W  left-shift amount per brick.
- brick_en  input  NUM_BRICKS  0 = brick skipped (zero weight slice), contributes 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  ACC_W  accumulated signed sum.
- out_beats  output  CNT_W  beats accepted in the window, including the last beat.
- out_ovf  output  1  sticky: the accumulator wrapped during the window.

Behaviour:
- Reset: state=ACCUM, acc=0, beat count=0, pipeline valid=0, ovf=0, out_valid=0, out_data=0, out_beats=0, out_ovf=0.
- Reset during ACCUM, FLUSH or HOLD discards everything in flight.
- Beat accepted when in_valid && in_ready. in_ready=1 only in state ACCUM.
- Stage 1 (registered):
  - term_i = brick_en[i] ? sign_extend(prod_in[i], ACC_W) <<< shift_in[i] : 0.
  - Store sum of all term_i (ACC_W bits, wraps), a valid bit and a last bit.
- Stage 2: when stage-1 valid, acc <= acc + sum.
  - ovf is set if signed overflow occurs in the add; it is also set if any brick's stage-1 term or the stage-1 summation wraps ACC_W (signed).
  - Beat counter increments on each accepted beat, saturating at all-ones.
- FSM states:
  - ACCUM: accepting beats. Accepting a beat with in_last=1 -> FLUSH.
  - FLUSH: in_ready=0. Waits until the last beat has been added to acc, then loads out_data=acc, out_beats, out_ovf, sets out_valid=1 -> HOLD.
  - HOLD: out_* held stable while out_valid && !out_ready.
    - On out_ready: out_valid=0, acc=0, count=0, ovf=0 -> ACCUM.
    - A new beat may be accepted on the cycle after the handshake.
- Latency: last beat accepted at edge t -> out_valid=1 after edge t+2. Minimum window period is (beats + 3) cycles.
- Single-beat window (in_last on the first beat) is legal: out_beats=1.
- Beats with all brick_en=0 are counted and contribute 0.
- clear takes priority over all other events in any state.
  - clear in HOLD drops the pending result: out_valid=0 next cycle.
  - clear together with an accepted beat: the beat is discarded.
- in_valid=0 cycles in ACCUM are idle and leave acc unchanged.
- An out-of-range shift_in (>12, or odd) is still shifted as given; no error is flagged.

Decomposition:
- Shared package bf_pkg holds:
  - constants BRICK_PROD_W=6, NUM_BRICKS, SHIFT_W, ACC_W;
  - enum accum_state_t {ACCUM, FLUSH, HOLD};
  - function brick_term(prod, shift, en) returning the ACC_W signed term.
- Sub-module brick_adder_tree: combinational sum of NUM_BRICKS terms. The parent keeps the stage-1 register, the accumulator and the FSM.

Test Plan:
- Reset values:
  - Stimulus: assert n_rst=0 mid-HOLD, with out_valid=1, out_data=37.
  - Required response: out_valid, out_data, out_beats and out_ovf go to 0 immediately (asynchronously), in_ready=1 after release.
- Single beat:
  - Stimulus: one beat with in_last=1; brick0 prod=6'h3C (-4) shift 0; brick1 prod=9 shift 4; other bricks disabled.
  - Required response: out_data=140, out_beats=1, out_valid two edges after acceptance.
- Three-beat window with an idle gap:
  - Stimulus: beat sums 5, -7, 100, with one in_valid=0 gap between beats 2 and 3.
  - Required response: out_data=98, out_beats=3, in_ready=0 in FLUSH and HOLD.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles.
  - Required response: out_data stable, in_ready=0 throughout. After the handshake, in_ready=1 and acc restarts from 0 (next window result equals that window's sum only).
- Sparsity and all-disabled beats:
  - Stimulus: brick_en=0 on bricks carrying nonzero products; then a beat with all brick_en=0.
  - Required response: masked bricks contribute nothing; the all-disabled beat is counted in out_beats and adds 0.
- Overflow and clear:
  - Stimulus: ACC_W=16 build; accumulate 3 beats of 16384.
  - Required response: out_ovf=1, out_data=wrapped value.
  - Stimulus: assert clear together with an accepted beat mid-window.
  - Required response: next window result excludes every beat before and including that beat.
